// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler.
// Detects qualified rising/falling edges per channel, keeps one pending event
// per channel, and hands events one at a time to a single consumer through a
// registered valid/ready output slot using round-robin arbitration.
module edge_event_arbiter #(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in,
  input  logic [N-1:0]   rise_en,
  input  logic [N-1:0]   fall_en,
  output logic           event_valid,
  input  logic           event_ready,
  output logic [IDW-1:0] event_id,
  output logic           event_rising,
  output logic [N-1:0]   overflow,
  input  logic           overflow_clr
);

  // Stage 0 state: input history, pending events and their polarity
  logic [N-1:0]   last_in_p0;
  logic [N-1:0]   pend_p0;
  logic [N-1:0]   pol_p0;

  // Round-robin search start
  logic [IDW-1:0] ptr;

  // Combinational edge terms and arbitration results
  logic [N-1:0]   rise;
  logic [N-1:0]   fall;
  logic [N-1:0]   ev;
  logic [N-1:0]   collision;
  logic [N-1:0]   grant;
  logic           slot_load;
  logic           found;
  logic           take;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] ptr_next;

  // Edge detection against the previous sample, qualified by the enables
  always_comb begin
    rise = in & ~last_in_p0;
    fall = ~in & last_in_p0;
    ev   = (rise & rise_en) | (fall & fall_en);
  end

  // Pick the first pending channel at or after ptr, wrapping around
  always_comb begin
    int idx;
    idx      = 0;
    found    = 1'b0;
    grant_id = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && pend_p0[IDW'(idx)]) begin
        found    = 1'b1;
        grant_id = IDW'(idx);
      end
    end
  end

  // Slot loads when empty or being accepted; grant only when something is pending
  always_comb begin
    slot_load = ~event_valid | event_ready;
    take      = slot_load & found;
    ptr_next  = (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
    grant     = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = take && (grant_id == IDW'(i));
    end
    // A new edge on a channel whose old event stays pending is dropped
    collision = ev & pend_p0 & ~grant;
  end

  // ---- stage 0: edge history, pending bits, overflow flags ----
  // Pending bit set by a qualified edge; a granted channel frees its slot the
  // same cycle so a simultaneous new edge is kept rather than dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      last_in_p0 <= '0;
      pend_p0    <= '0;
      pol_p0     <= '0;
      overflow   <= '0;
    end else begin
      last_in_p0 <= in;
      for (int i = 0; i < N; i++) begin
        if (ev[i] && (!pend_p0[i] || grant[i])) begin
          pend_p0[i] <= 1'b1;
          pol_p0[i]  <= rise[i];
        end else if (grant[i]) begin
          pend_p0[i] <= 1'b0;
        end
      end
      // A collision in the same cycle as the clear leaves its bit set
      overflow <= (overflow & ~{N{overflow_clr}}) | collision;
    end
  end

  // ---- stage 1: registered output slot and round-robin pointer ----
  // Slot holds steady while valid and not ready; otherwise takes the grant or empties
  always_ff @(posedge clk) begin
    if (rst) begin
      event_valid  <= 1'b0;
      event_id     <= '0;
      event_rising <= 1'b0;
      ptr          <= '0;
    end else if (slot_load) begin
      event_valid <= found;
      if (found) begin
        event_id     <= grant_id;
        event_rising <= pol_p0[grant_id];
        ptr          <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Testbench for edge_event_arbiter: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the scheduler.
module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = $clog2(N);

  logic           clk;
  logic           rst;
  logic [N-1:0]   in;
  logic [N-1:0]   rise_en;
  logic [N-1:0]   fall_en;
  logic           event_valid;
  logic           event_ready;
  logic [IDW-1:0] event_id;
  logic           event_rising;
  logic [N-1:0]   overflow;
  logic           overflow_clr;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_last [N];
  bit m_pend [N];
  bit m_pol  [N];
  bit m_ovf  [N];
  int m_ptr;
  bit m_vld;
  int m_id;
  bit m_rise;

  edge_event_arbiter #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .rise_en      (rise_en),
    .fall_en      (fall_en),
    .event_valid  (event_valid),
    .event_ready  (event_ready),
    .event_id     (event_id),
    .event_rising (event_rising),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_ovf();
    logic [N-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c] = m_ovf[c];
    return v;
  endfunction

  // One clock of the scheduler's rules, using the inputs present at the edge
  task automatic model_step();
    int g;
    bit take;
    bit e;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        m_last[c] = 0; m_pend[c] = 0; m_pol[c] = 0; m_ovf[c] = 0;
      end
      m_ptr = 0; m_vld = 0; m_id = 0; m_rise = 0;
      return;
    end
    take = !m_vld || event_ready;
    g = -1;
    if (take) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && m_pend[c]) g = c;
      end
      if (g >= 0) begin
        m_vld  = 1;
        m_id   = g;
        m_rise = m_pol[g];
        m_ptr  = (g + 1) % N;
      end else begin
        m_vld = 0;
      end
    end
    if (overflow_clr) for (int c = 0; c < N; c++) m_ovf[c] = 0;
    for (int c = 0; c < N; c++) begin
      e = (in[c] && !m_last[c] && rise_en[c]) || (!in[c] && m_last[c] && fall_en[c]);
      if (c == g) m_pend[c] = 0;
      if (e) begin
        if (m_pend[c]) m_ovf[c] = 1;
        else begin
          m_pend[c] = 1;
          m_pol[c]  = in[c];
        end
      end
      m_last[c] = in[c];
    end
  endtask

  // Advance one clock, update the model at the edge, compare just after it
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("valid", event_valid, m_vld);
    check("id", event_id, m_id);
    check("rising", event_rising, m_rise);
    check("overflow", overflow, model_ovf());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_valid", event_valid, 0);
    check("rst_overflow", overflow, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    in           = '0;
    rise_en      = '1;
    fall_en      = '1;
    event_ready  = 1'b1;
    overflow_clr = 1'b0;

    // Single rising edge on channel 2
    do_reset();
    tick();
    in[2] = 1'b1;
    tick();
    check("t1_pend_valid", event_valid, 0);
    tick();
    check("t1_valid", event_valid, 1);
    check("t1_id", event_id, 2);
    check("t1_rising", event_rising, 1);
    check("t1_overflow", overflow, 0);
    tick();
    check("t1_valid_drop", event_valid, 0);

    // Simultaneous edges on 0, 1, 3 from a fresh pointer
    in = '0;
    do_reset();
    in = 4'b1011;
    tick();
    tick();
    check("t2_id_a", event_id, 0);
    tick();
    check("t2_id_b", event_id, 1);
    tick();
    check("t2_id_c", event_id, 3);
    check("t2_valid_c", event_valid, 1);
    tick();
    check("t2_empty", event_valid, 0);
    in[0] = 1'b0;
    in[3] = 1'b0;
    tick();
    tick();
    check("t2_rr_first", event_id, 0);
    tick();
    check("t2_rr_second", event_id, 3);
    in[1] = 1'b0;
    repeat (3) tick();

    // Falling-only channel 1 with a 3-cycle pulse
    rise_en = 4'b1101;
    in[1] = 1'b1;
    repeat (3) begin
      tick();
      check("t3_quiet", event_valid, 0);
    end
    in[1] = 1'b0;
    tick();
    check("t3_pend", event_valid, 0);
    tick();
    check("t3_valid", event_valid, 1);
    check("t3_id", event_id, 1);
    check("t3_rising", event_rising, 0);
    tick();
    check("t3_single", event_valid, 0);
    rise_en = '1;

    // Back-pressure, pending behind held slot, then overflow
    event_ready = 1'b0;
    in[0] = 1'b1;
    tick();
    in[0] = 1'b0;
    tick();
    check("t4_hold_id", event_id, 0);
    check("t4_hold_rise", event_rising, 1);
    check("t4_no_ovf", overflow, 0);
    in[0] = 1'b1;
    tick();
    check("t4_still_valid", event_valid, 1);
    check("t4_still_rise", event_rising, 1);
    check("t4_ovf", overflow, 4'b0001);
    event_ready = 1'b1;
    tick();
    check("t4_drain_valid", event_valid, 1);
    check("t4_drain_rise", event_rising, 0);
    tick();
    check("t4_drained", event_valid, 0);

    // Clear overflow with no competing collision
    overflow_clr = 1'b1;
    tick();
    check("t5_clear", overflow, 0);
    overflow_clr = 1'b0;

    // Collision on the same cycle as the clear
    event_ready = 1'b0;
    in[0] = 1'b0;
    tick();
    tick();
    in[0] = 1'b1;
    tick();
    check("t6_pre", overflow, 0);
    in[0] = 1'b0;
    overflow_clr = 1'b1;
    tick();
    check("t6_set_wins", overflow, 4'b0001);
    overflow_clr = 1'b0;
    event_ready = 1'b1;
    repeat (4) tick();

    // Reset mid-handshake with other events pending
    event_ready = 1'b0;
    in = 4'b0111;
    tick();
    tick();
    check("t7_held", event_valid, 1);
    in = 4'b0100;
    rst = 1'b1;
    tick();
    check("t7_rst_valid", event_valid, 0);
    check("t7_rst_id", event_id, 0);
    check("t7_rst_rise", event_rising, 0);
    rst = 1'b0;
    event_ready = 1'b1;
    tick();
    check("t7_after_quiet", event_valid, 0);
    tick();
    check("t7_valid", event_valid, 1);
    check("t7_id", event_id, 2);
    check("t7_rise", event_rising, 1);
    repeat (3) begin
      tick();
      check("t7_no_stale", event_valid, 0);
    end

    // Randomized traffic: fast toggling, then sparse toggling
    for (int n = 0; n < 1500; n++) begin
      if (n < 700) in = N'($urandom);
      else if ($urandom_range(2) == 0) in = in ^ N'(1 << $urandom_range(N - 1));
      rise_en      = N'($urandom | $urandom);
      fall_en      = N'($urandom | $urandom);
      event_ready  = ($urandom_range(3) != 0);
      overflow_clr = ($urandom_range(15) == 0);
      rst          = ($urandom_range(199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
